// File: rtl/platform_pio_edge_in.sv
// Parallel input port with per-bit edge capture, interrupt mask and registered read mux.
// Optional debounce filter is compiled in with `define PLATFORM_PIO_DEBOUNCE_EN.
module platform_pio_edge_in #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned IRQ_TYPE        = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH == 0 || WIDTH > 32 || EDGE_TYPE > 2 || IRQ_TYPE > 1 || DEBOUNCE_CYCLES == 0)
  begin : g_param_err
    $error("platform_pio_edge_in: illegal parameter value");
  end

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_data_in;
  logic [WIDTH-1:0] r_data_prev;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PLATFORM_PIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] r_db_cnt;
  logic [WIDTH-1:0]            r_db_data;

  // A bit only follows the synchronized pin after it has disagreed for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt  <= '0;
      r_db_data <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (r_sync2[i] == r_db_data[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_LAST) begin
          r_db_data[i] <= r_sync2[i];
          r_db_cnt[i]  <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_data_in = r_db_data;
`else
  assign w_data_in = r_sync2;
`endif

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = ~r_data_prev & w_data_in;
      1:       w_edge = r_data_prev & ~w_data_in;
      default: w_edge = r_data_prev ^ w_data_in;
    endcase
  end

  assign w_wr           = chipselect & ~write_n;
  assign w_clr          = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = ^writedata;

  // Set wins over a simultaneous clear so no edge is ever lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_prev <= '0;
      r_edgecap   <= '0;
      r_irq_mask  <= '0;
    end else begin
      r_data_prev <= w_data_in;
      r_edgecap   <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && address == 2'd2) begin
        r_irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      2'd0:    w_rdata = 32'(w_data_in);
      2'd2:    w_rdata = 32'(r_irq_mask);
      2'd3:    w_rdata = 32'(r_edgecap);
      default: w_rdata = '0;
    endcase
  end

  // Read data refreshes every clock regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdata;
    end
  end

  assign irq = (IRQ_TYPE == 0) ? |(w_data_in & r_irq_mask) : |(r_edgecap & r_irq_mask);

endmodule

// File: tb/tb_platform_pio_edge_in.sv
// Directed bench for platform_pio_edge_in: rising/falling/any capture, level and edge irq,
// clear/set collision, read latency, reset behaviour and (when compiled in) debounce.
module tb_platform_pio_edge_in;

`ifdef PLATFORM_PIO_DEBOUNCE_EN
  localparam int DLAT = 16;
`else
  localparam int DLAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_rise, rd_fall, rd_any, rd_lvl;
  logic        irq_rise, irq_fall, irq_any, irq_lvl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  platform_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(1), .DEBOUNCE_CYCLES(16)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_rise), .irq(irq_rise));
  platform_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_TYPE(1), .DEBOUNCE_CYCLES(16)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_fall), .irq(irq_fall));
  platform_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(1), .DEBOUNCE_CYCLES(16)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_any), .irq(irq_any));
  platform_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(0), .DEBOUNCE_CYCLES(16)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_lvl), .irq(irq_lvl));

  typedef struct {
    logic [7:0] prev;
    logic [7:0] nxt;
    logic [7:0] mask;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] any;
    logic       irq_e;
    logic       irq_l;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (5 + DLAT) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h05, 8'h04, 8'h05, 8'h00, 8'h05, 1'b1, 1'b1};
    vecs[1] = '{8'h05, 8'h00, 8'hFF, 8'h00, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[2] = '{8'h0F, 8'hF0, 8'h10, 8'hF0, 8'h0F, 8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'h3C, 8'hC3, 8'h01, 8'hC3, 8'h3C, 8'hFF, 1'b1, 1'b1};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", rd_rise, 32'h0);
    chk("reset_irq", 32'(irq_rise), 32'h0);
    chk("reset_irq_lvl", 32'(irq_lvl), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    settle();
    bus_read(2'd3);
    chk("no_edge_after_reset_low", rd_rise, 32'h0);

    // Table of capture / irq vectors
    for (int i = 0; i < 8; i++) begin
      in_port = vecs[i].prev;
      settle();
      bus_write(2'd3, 32'hFF);
      bus_write(2'd2, 32'(vecs[i].mask));
      in_port = vecs[i].nxt;
      settle();
      bus_read(2'd3);
      chk($sformatf("vec%0d_cap_rise", i), rd_rise, 32'(vecs[i].rise));
      chk($sformatf("vec%0d_cap_fall", i), rd_fall, 32'(vecs[i].fall));
      chk($sformatf("vec%0d_cap_any", i),  rd_any,  32'(vecs[i].any));
      chk($sformatf("vec%0d_irq_edge", i), 32'(irq_rise), 32'(vecs[i].irq_e));
      chk($sformatf("vec%0d_irq_level", i), 32'(irq_lvl), 32'(vecs[i].irq_l));
      bus_read(2'd0);
      chk($sformatf("vec%0d_data_in", i), rd_rise, 32'(vecs[i].nxt));
      bus_read(2'd2);
      chk($sformatf("vec%0d_mask_rb", i), rd_rise, 32'(vecs[i].mask));
    end

    // Clearing the last masked capture bit drops irq right after the write
    in_port = 8'h00;
    settle();
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h0000_FF04);
    in_port = 8'h05;
    settle();
    chk("clr_irq_before", 32'(irq_rise), 32'h1);
    bus_write(2'd3, 32'h04);
    chk("clr_irq_after", 32'(irq_rise), 32'h0);
    bus_read(2'd3);
    chk("clr_cap_after", rd_rise, 32'h01);
    bus_read(2'd2);
    chk("mask_upper_ignored", rd_rise, 32'h04);

    // Writing mask to zero drops irq immediately
    in_port = 8'h00;
    settle();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h04;
    settle();
    chk("mask0_irq_before", 32'(irq_rise), 32'h1);
    bus_write(2'd2, 32'h0);
    chk("mask0_irq_after", 32'(irq_rise), 32'h0);

    // Writes to addresses 0 and 1 have no effect
    bus_write(2'd0, 32'hFF);
    bus_write(2'd1, 32'hFF);
    bus_read(2'd2);
    chk("wr_addr01_mask", rd_rise, 32'h0);
    bus_read(2'd3);
    chk("wr_addr01_cap", rd_rise, 32'h04);

    // Edge detected in the same cycle as a clear of that bit: set wins
    in_port = 8'h00;
    settle();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h01;
    repeat (2 + DLAT) tick();
    bus_write(2'd3, 32'h01);
    bus_read(2'd3);
    chk("collide_set_wins", rd_rise, 32'h01);
    bus_write(2'd3, 32'h01);
    bus_read(2'd3);
    chk("clear_after_collide", rd_rise, 32'h00);

    // Read mux has one clock of latency from address
    address = 2'd0;
    @(negedge clk);
    chk("rd_latency_old", rd_rise, 32'h00);
    tick();
    chk("rd_latency_new", rd_rise, 32'h01);

    // Asynchronous reset mid-operation with everything set
    in_port = 8'h00;
    settle();
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'hFF);
    in_port = 8'hFF;
    settle();
    bus_read(2'd3);
    chk("pre_reset_cap", rd_rise, 32'hFF);
    chk("pre_reset_irq", 32'(irq_rise), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_readdata", rd_rise, 32'h0);
    chk("mid_reset_irq", 32'(irq_rise), 32'h0);
    chk("mid_reset_irq_lvl", 32'(irq_lvl), 32'h0);
    in_port = 8'h00;
    repeat (2) tick();
    chk("hold_reset_irq", 32'(irq_rise), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    settle();
    bus_read(2'd2);
    chk("post_reset_mask", rd_rise, 32'h0);
    bus_read(2'd3);
    chk("post_reset_cap", rd_rise, 32'h0);

    // Inputs high at reset release produce a rising edge
    in_port = 8'hFF;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    settle();
    bus_read(2'd3);
    chk("release_high_rise", rd_rise, 32'hFF);
    chk("release_high_fall", rd_fall, 32'h00);

`ifdef PLATFORM_PIO_DEBOUNCE_EN
    // Glitch shorter than the window is filtered; a long pulse gets through
    in_port = 8'h00;
    repeat (40) tick();
    bus_write(2'd3, 32'hFF);
    in_port = 8'h02;
    repeat (10) tick();
    in_port = 8'h00;
    repeat (40) tick();
    bus_read(2'd3);
    chk("db_short_cap", rd_rise, 32'h00);
    in_port = 8'h02;
    repeat (20) tick();
    bus_read(2'd0);
    chk("db_long_data", rd_rise, 32'h02);
    in_port = 8'h00;
    repeat (40) tick();
    bus_read(2'd3);
    chk("db_long_cap", rd_rise, 32'h02);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
